lcd_rgb_rx: RTL and testbench

// - Receive side of the parallel RGB565 LCD interface (DE, HSYNC, VSYNC, 16-bit colour) on one pixel clock.
// - Decodes the timing and emits a pixel stream tagged with x/y coordinates.
// - Measures frame geometry and locks when the measured geometry matches the expected panel size.
// - Used as a loopback checker for the panel timing generator and as a capture front-end.

---
 rtl/lcd_rgb_rx.sv | 187 ++++++++++++++++++
 tb/tb_lcd_rgb_rx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lcd_rgb_rx.sv
// RGB565 parallel LCD receiver: decodes DE/HSYNC/VSYNC into an x/y-tagged pixel
// stream, measures frame geometry and locks when it matches the expected panel.
module lcd_rgb_rx #(
  parameter int unsigned CW          = 16,
  parameter int unsigned EXP_WIDTH   = 800,
  parameter int unsigned EXP_HEIGHT  = 480,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned HTIMEOUT    = 4096
) (
  input  logic          PixelClk,
  input  logic          nRST,
  input  logic          LCD_DE,
  input  logic          LCD_HSYNC,
  input  logic          LCD_VSYNC,
  input  logic [4:0]    LCD_R,
  input  logic [5:0]    LCD_G,
  input  logic [4:0]    LCD_B,
  output logic          pix_valid,
  output logic [15:0]   pix_rgb,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          sof,
  output logic          eol,
  output logic [CW-1:0] meas_width,
  output logic [CW-1:0] meas_height,
  output logic [CW-1:0] meas_htotal,
  output logic [CW-1:0] meas_lines,
  output logic          locked,
  output logic          err_geom
);

  localparam int unsigned TW = $clog2(HTIMEOUT + 1);
  localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  logic          r_a_de, r_a_hs, r_a_vs, r_b_de, r_b_hs, r_b_vs;
  logic [15:0]   r_a_rgb, r_b_rgb;
  logic [CW-1:0] r_xcnt, r_ycnt, r_rows, r_lines, r_hcnt;
  logic [TW-1:0] r_tcnt;
  logic [GW-1:0] r_good_cnt;
  logic          r_line_bad;
  state_t        r_state;

  logic          w_hfall, w_vfall, w_defall, w_valid, w_timeout, w_frame_good;
  logic [CW-1:0] w_wlen;
  logic [GW-1:0] w_gnext;

  assign w_hfall      = r_b_hs & ~r_a_hs;
  assign w_vfall      = r_b_vs & ~r_a_vs;
  assign w_defall     = r_b_de & ~r_a_de;
  assign w_valid      = r_b_de && (r_state != SEARCH);
  assign w_wlen       = sat_inc(r_xcnt);
  assign w_timeout    = !w_hfall && (r_tcnt == TW'(HTIMEOUT - 1));
  assign w_gnext      = r_good_cnt + GW'(1);
  assign w_frame_good = (32'(meas_width) == EXP_WIDTH) && (32'(r_rows) == EXP_HEIGHT) && !r_line_bad;

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      {r_a_de, r_a_hs, r_a_vs, r_b_de, r_b_hs, r_b_vs} <= '0;
      r_a_rgb <= '0;
      r_b_rgb <= '0;
    end else begin
      r_a_de  <= LCD_DE;
      r_a_hs  <= LCD_HSYNC;
      r_a_vs  <= LCD_VSYNC;
      r_a_rgb <= {LCD_R, LCD_G, LCD_B};
      r_b_de  <= r_a_de;
      r_b_hs  <= r_a_hs;
      r_b_vs  <= r_a_vs;
      r_b_rgb <= r_a_rgb;
    end
  end

  // Pixel stream: r_xcnt/r_ycnt hold the coordinate of the pixel now in stage B.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      pix_valid <= 1'b0;
      pix_rgb   <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      r_xcnt    <= '0;
      r_ycnt    <= '0;
    end else begin
      pix_valid <= w_valid;
      pix_rgb   <= w_valid ? r_b_rgb : '0;
      eol       <= w_valid && !r_a_de;
      sof       <= w_valid && (r_xcnt == '0) && (r_ycnt == '0);
      if (r_b_de) begin
        pix_x  <= r_xcnt;
        pix_y  <= r_ycnt;
        r_xcnt <= w_wlen;
      end else begin
        r_xcnt <= '0;
      end
      if (w_vfall)       r_ycnt <= '0;
      else if (w_defall) r_ycnt <= sat_inc(r_ycnt);
    end
  end

  // vfall is handled after de_fall/hfall so a coincident hfall opens the new frame.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      meas_width  <= '0;
      meas_height <= '0;
      meas_htotal <= '0;
      meas_lines  <= '0;
      r_rows      <= '0;
      r_lines     <= '0;
      r_hcnt      <= '0;
      r_tcnt      <= '0;
      r_line_bad  <= 1'b0;
    end else begin
      if (w_defall) begin
        meas_width <= w_wlen;
        r_rows     <= sat_inc(r_rows);
        if ((r_rows != '0) && (w_wlen != meas_width)) r_line_bad <= 1'b1;
      end
      if (w_hfall) begin
        meas_htotal <= r_hcnt;
        r_hcnt      <= CW'(1);
        r_tcnt      <= '0;
        r_lines     <= sat_inc(r_lines);
      end else begin
        r_hcnt <= sat_inc(r_hcnt);
        if (r_tcnt != TW'(HTIMEOUT - 1)) r_tcnt <= r_tcnt + TW'(1);
      end
      if (w_vfall) begin
        meas_height <= r_rows;
        meas_lines  <= r_lines;
        r_rows      <= '0;
        r_line_bad  <= 1'b0;
        r_lines     <= w_hfall ? CW'(1) : '0;
      end
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      r_state    <= SEARCH;
      r_good_cnt <= '0;
      locked     <= 1'b0;
      err_geom   <= 1'b0;
    end else begin
      err_geom <= 1'b0;
      if (w_timeout) begin
        r_state    <= SEARCH;
        r_good_cnt <= '0;
        locked     <= 1'b0;
      end else if (w_vfall) begin
        case (r_state)
          SEARCH: begin
            r_state    <= CHECK;
            r_good_cnt <= '0;
          end
          CHECK: begin
            if (!w_frame_good) begin
              r_good_cnt <= '0;
            end else if (w_gnext == GW'(LOCK_FRAMES)) begin
              r_state    <= LOCKED;
              r_good_cnt <= '0;
              locked     <= 1'b1;
            end else begin
              r_good_cnt <= w_gnext;
            end
          end
          LOCKED: begin
            if (!w_frame_good) begin
              r_state    <= CHECK;
              r_good_cnt <= '0;
              locked     <= 1'b0;
              err_geom   <= 1'b1;
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Scoreboard bench for lcd_rgb_rx on a scaled-down panel (16x6 active, 40x10 total)
// plus a CW=8 instance for counter saturation.
module tb_lcd_rgb_rx;

  localparam int W     = 16;
  localparam int H     = 6;
  localparam int HT    = 40;
  localparam int NL    = 10;
  localparam int HS    = 4;
  localparam int DEOFF = 10;
  localparam int VOFF  = 20;
  localparam int ACT0  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       de, hs, vs;
  logic [4:0] r, b;
  logic [5:0] g;

  logic        pix_valid, sof, eol, locked, err_geom;
  logic [15:0] pix_rgb, pix_x, pix_y, meas_width, meas_height, meas_htotal, meas_lines;

  logic        pix_valid8, sof8, eol8, locked8, err_geom8;
  logic [15:0] pix_rgb8;
  logic [7:0]  pix_x8, pix_y8, meas_width8, meas_height8, meas_htotal8, meas_lines8;

  int n_total = 0;
  int n_pass  = 0;
  int n_err   = 0;
  logic armed  = 1'b0;
  logic mon_en = 1'b1;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  lcd_rgb_rx #(.CW(16), .EXP_WIDTH(W), .EXP_HEIGHT(H), .LOCK_FRAMES(2), .HTIMEOUT(100)) u_dut (
    .PixelClk(clk), .nRST(rst_n), .LCD_DE(de), .LCD_HSYNC(hs), .LCD_VSYNC(vs),
    .LCD_R(r), .LCD_G(g), .LCD_B(b),
    .pix_valid(pix_valid), .pix_rgb(pix_rgb), .pix_x(pix_x), .pix_y(pix_y),
    .sof(sof), .eol(eol), .meas_width(meas_width), .meas_height(meas_height),
    .meas_htotal(meas_htotal), .meas_lines(meas_lines), .locked(locked), .err_geom(err_geom)
  );

  lcd_rgb_rx #(.CW(8), .EXP_WIDTH(800), .EXP_HEIGHT(H), .LOCK_FRAMES(2), .HTIMEOUT(2000)) u_dut8 (
    .PixelClk(clk), .nRST(rst_n), .LCD_DE(de), .LCD_HSYNC(hs), .LCD_VSYNC(vs),
    .LCD_R(r), .LCD_G(g), .LCD_B(b),
    .pix_valid(pix_valid8), .pix_rgb(pix_rgb8), .pix_x(pix_x8), .pix_y(pix_y8),
    .sof(sof8), .eol(eol8), .meas_width(meas_width8), .meas_height(meas_height8),
    .meas_htotal(meas_htotal8), .meas_lines(meas_lines8), .locked(locked8), .err_geom(err_geom8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // mode 0: VSYNC falls mid line 0; mode 1: VSYNC falls with HSYNC; mode 2: no VSYNC
  task automatic drive_frame(input int mode, input int short_row, input int ht, input int delen);
    logic [15:0] rgb;
    int row, len;
    if (mode != 2) armed = 1'b1;
    for (int ln = 0; ln < NL; ln++) begin
      for (int c = 0; c < ht; c++) begin
        @(negedge clk);
        hs = (c >= HS);
        case (mode)
          0:       vs = !(ln == 0 && c >= VOFF);
          1:       vs = (ln != 0);
          default: vs = 1'b1;
        endcase
        row = ln - ACT0;
        len = (row == short_row) ? delen - 1 : delen;
        de  = (row >= 0 && row < H && c >= DEOFF && c < DEOFF + len);
        if (de) begin
          rgb = 16'($urandom);
          {r, g, b} = rgb;
          if (armed && mon_en)
            sb.push_back({rgb, 16'(c - DEOFF), 16'(row), 14'd0,
                          (c == DEOFF + len - 1), (c == DEOFF && row == 0)});
        end else begin
          {r, g, b} = '0;
        end
      end
    end
  endtask

  task automatic hold(input int n, input logic d);
    repeat (n) begin
      @(negedge clk);
      de = d; hs = 1'b1; vs = 1'b1;
      {r, g, b} = 16'($urandom);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (pix_valid) begin
        if (sb.size() == 0) check("unexpected_pixel", {pix_x, pix_y}, '1);
        else check("pixel", {pix_rgb, pix_x, pix_y, 14'd0, eol, sof}, sb.pop_front());
      end else if (sof || eol) begin
        check("stray_pulse", {62'd0, sof, eol}, '0);
      end
      if (err_geom) n_err++;
    end
  end

  initial begin
    rst_n = 1'b0;
    de = 1'b0; hs = 1'b1; vs = 1'b1; {r, g, b} = '0;
    repeat (12) begin
      @(negedge clk);
      {de, hs, vs} = 3'($urandom);
      {r, g, b} = 16'($urandom);
    end
    check("rst_outs", {pix_valid, pix_rgb, pix_x, pix_y, sof, eol, locked, err_geom}, '0);
    check("rst_meas", {meas_width, meas_height, meas_htotal, meas_lines}, '0);
    check("rst_outs8", {pix_valid8, pix_rgb8, pix_x8, pix_y8, sof8, eol8, locked8, err_geom8,
                        meas_width8, meas_height8, meas_htotal8, meas_lines8}, '0);
    hold(2, 1'b0);
    rst_n = 1'b1;

    drive_frame(2, -1, HT, W);
    check("search_no_valid", {pix_valid, locked}, '0);

    drive_frame(0, -1, HT, W);
    drive_frame(0, -1, HT, W);
    check("not_locked_f2", locked, 1'b0);
    drive_frame(0, -1, HT, W);
    check("locked_f3", locked, 1'b1);
    check("meas_geom", {meas_width, meas_height, meas_htotal, meas_lines},
          {16'(W), 16'(H), 16'(HT), 16'(NL)});

    drive_frame(0, 3, HT, W);
    check("locked_before_bad", {locked, 8'(n_err)}, {1'b1, 8'd0});
    drive_frame(0, -1, HT, W);
    check("err_after_bad", {locked, 8'(n_err)}, {1'b0, 8'd1});
    drive_frame(0, -1, HT, W);
    check("relock_wait", locked, 1'b0);
    drive_frame(0, -1, HT, W);
    check("relocked", {locked, 8'(n_err)}, {1'b1, 8'd1});

    hold(40, 1'b0);
    check("timeout_not_yet", locked, 1'b1);
    hold(110, 1'b0);
    check("timeout_unlock", locked, 1'b0);
    check("meas_held", {meas_width, meas_htotal}, {16'(W), 16'(HT)});
    armed = 1'b0;
    hold(20, 1'b1);
    hold(4, 1'b0);
    check("search_gates_valid", pix_valid, 1'b0);

    drive_frame(1, -1, HT, W);
    drive_frame(1, -1, HT, W);
    check("coinc_lines", meas_lines, 16'(NL));
    drive_frame(0, -1, HT, W);
    check("coinc_new_frame_lines", meas_lines, 16'(NL + 1));
    hold(6, 1'b0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    mon_en = 1'b0;
    armed  = 1'b0;
    repeat (3) drive_frame(0, -1, 320, 300);
    check("sat_width8", {meas_width8, meas_htotal8, meas_height8}, {8'd255, 8'd255, 8'(H)});
    check("no_lock8", locked8, 1'b0);
    check("width16_300", meas_width, 16'd300);

    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst", {meas_width, locked, meas_width8}, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
